// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage MIPS core: stall arbitration and exception/ERET redirect sequencing.
// Optional stall performance counter enabled by defining PIPE_STALL_PERF_EN.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE   = 32'h0000000E,
    parameter int unsigned FLUSH_GUARD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] exception_type,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FREEZE = 2'd1,
        FLUSH  = 2'd2,
        GUARD  = 2'd3
    } state_t;

    localparam logic [3:0] GUARD_LOAD = 4'(FLUSH_GUARD);

    state_t      state_r;
    state_t      next_state_s;
    logic [3:0]  guard_cnt_r;
    logic [31:0] cause_r;
    logic [31:0] epc_r;
    logic [31:0] new_pc_r;
    logic        flush_r;
    logic [5:0]  arb_s;
    logic [5:0]  stall_s;
    logic        exc_take_s;

    // Highest requesting stage wins; each stall also freezes everything upstream of it.
    always_comb begin
        arb_s = 6'b000000;
        if (stallreq_mem) begin
            arb_s = 6'b011111;
        end else if (stallreq_ex) begin
            arb_s = 6'b001111;
        end else if (stallreq_id) begin
            arb_s = 6'b000111;
        end else if (stallreq_if) begin
            arb_s = 6'b000011;
        end else begin
            arb_s = 6'b000000;
        end
    end

    // Next-state and stall decode.
    always_comb begin
        next_state_s = state_r;
        stall_s      = 6'b000000;
        exc_take_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // An exception is held off while MEM is still waiting on the data bus.
                if ((exception_type != 32'h0) && !stallreq_mem) begin
                    next_state_s = FREEZE;
                    exc_take_s   = 1'b1;
                    stall_s      = 6'b000000;
                end else begin
                    next_state_s = IDLE;
                    stall_s      = arb_s;
                end
            end
            FREEZE: begin
                next_state_s = FLUSH;
                stall_s      = 6'b111111;
            end
            FLUSH: begin
                stall_s = 6'b000000;
                if (GUARD_LOAD != 4'd0) begin
                    next_state_s = GUARD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GUARD: begin
                stall_s = arb_s;
                if (guard_cnt_r <= 4'd1) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = GUARD;
                end
            end
            default: begin
                next_state_s = IDLE;
                stall_s      = 6'b000000;
            end
        endcase
    end

    // State, latched cause/EPC, redirect target and guard counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            guard_cnt_r <= 4'd0;
            cause_r     <= 32'h0;
            epc_r       <= 32'h0;
            new_pc_r    <= 32'h0;
            flush_r     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            flush_r <= (next_state_s == FLUSH);
            if (exc_take_s) begin
                cause_r <= exception_type;
                epc_r   <= cp0_epc;
            end
            if (state_r == FREEZE) begin
                new_pc_r <= (cause_r == ERET_CODE) ? epc_r : EXC_VECTOR;
            end
            if (state_r == FLUSH) begin
                guard_cnt_r <= GUARD_LOAD;
            end else if ((state_r == GUARD) && (guard_cnt_r != 4'd0)) begin
                guard_cnt_r <= guard_cnt_r - 4'd1;
            end
        end
    end

    assign stall  = rst ? stall_s : 6'b000000;
    assign flush  = flush_r;
    assign new_pc = new_pc_r;

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= 32'h0;
        end else if (stall[0] && (stall_cnt_r != 32'hFFFFFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_r;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed vector table, perf-counter sequence, and a randomized run
// checked against a queue-based schedule model.
module tb_pipe_ctrl;

    localparam logic [31:0] EXC_VEC   = 32'hBFC00380;
    localparam logic [31:0] ERET      = 32'h0000000E;
    localparam int          GUARD_LEN = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] exception_type, cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.EXC_VECTOR(EXC_VEC), .ERET_CODE(ERET), .FLUSH_GUARD(GUARD_LEN)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .exception_type(exception_type), .cp0_epc(cp0_epc),
        .stall(stall), .flush(flush), .new_pc(new_pc), .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;     // {mem, ex, id, if}
        logic [31:0] exc;
        logic [31:0] epc;
        logic [5:0]  st;
        logic        fl;
        logic        chk_pc;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] q, input logic [31:0] e, input logic [31:0] p,
                       input logic [5:0] s, input logic f, input logic c, input logic [31:0] pc);
        vec_t v;
        v.rst = r; v.req = q; v.exc = e; v.epc = p; v.st = s; v.fl = f; v.chk_pc = c; v.pc = pc;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic [31:0] e, input logic [31:0] p);
        rst = r;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = q;
        exception_type = e;
        cp0_epc = p;
    endtask

    task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a queue of scheduled phases (1=freeze, 2=flush, 3=guard); empty queue = idle.
    int          sched_q[$];
    logic [31:0] m_target;
    logic [31:0] m_cnt;
    bit          m_cnt_known;

    function automatic logic [5:0] model_stall(input logic r, input logic [3:0] q, input logic [31:0] e);
        int ph;
        ph = (sched_q.size() != 0) ? sched_q[0] : 0;
        if (!r) return 6'b000000;
        if (ph == 1) return 6'b111111;
        if (ph == 2) return 6'b000000;
        if (ph == 0 && e != 32'h0 && !q[3]) return 6'b000000;
        if (q[3]) return 6'b011111;
        if (q[2]) return 6'b001111;
        if (q[1]) return 6'b000111;
        if (q[0]) return 6'b000011;
        return 6'b000000;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] q, input logic [31:0] e, input logic [31:0] p,
                              input logic [5:0] st_now);
        int ph;
        if (!r) begin
            sched_q.delete();
            m_cnt = 32'h0;
            m_cnt_known = 1'b1;
        end else begin
            if (st_now[0] && m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 32'd1;
            ph = (sched_q.size() != 0) ? sched_q[0] : 0;
            if (sched_q.size() != 0) void'(sched_q.pop_front());
            if (ph == 0 && e != 32'h0 && !q[3]) begin
                sched_q.push_back(1);
                sched_q.push_back(2);
                for (int g = 0; g < GUARD_LEN; g++) sched_q.push_back(3);
                m_target = (e == ERET) ? p : EXC_VEC;
            end
        end
    endtask

    initial begin
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // hazard priority
        add(0, 4'b1010, 32'h0, 32'h0, 6'b000000, 0, 1, 32'h0);
        add(1, 4'b0010, 32'h0, 32'h0, 6'b000111, 0, 0, 32'h0);
        add(1, 4'b1010, 32'h0, 32'h0, 6'b011111, 0, 0, 32'h0);
        add(1, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0);
        add(1, 4'b0001, 32'h0, 32'h0, 6'b000011, 0, 0, 32'h0);
        add(1, 4'b0101, 32'h0, 32'h0, 6'b001111, 0, 0, 32'h0);
        // syscall
        add(1, 4'b0000, 32'h8, 32'h0, 6'b000000, 0, 0, 32'h0);
        add(1, 4'b0000, 32'h0, 32'h0, 6'b111111, 0, 0, 32'h0);
        add(1, 4'b0000, 32'h0, 32'h0, 6'b000000, 1, 1, EXC_VEC);
        add(1, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0);
        // ERET with a simultaneous ID hazard; requests ignored during freeze
        add(1, 4'b0010, ERET, 32'h80001234, 6'b000000, 0, 0, 32'h0);
        add(1, 4'b1010, 32'h0, 32'h0, 6'b111111, 0, 0, 32'h0);
        add(1, 4'b0010, 32'h0, 32'h0, 6'b000000, 1, 1, 32'h80001234);
        // guard window ignores a new exception, the next cycle accepts it
        add(1, 4'b0000, 32'h8, 32'h0, 6'b000000, 0, 0, 32'h0);
        add(1, 4'b0000, 32'h8, 32'h0, 6'b000000, 0, 0, 32'h0);
        add(1, 4'b0000, 32'h0, 32'h0, 6'b111111, 0, 0, 32'h0);
        add(1, 4'b0000, 32'h0, 32'h0, 6'b000000, 1, 1, EXC_VEC);
        add(1, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0);
        // deferred exception behind a MEM stall
        add(1, 4'b1000, 32'h8, 32'h0, 6'b011111, 0, 0, 32'h0);
        add(1, 4'b1000, 32'h8, 32'h0, 6'b011111, 0, 0, 32'h0);
        add(1, 4'b1000, 32'h8, 32'h0, 6'b011111, 0, 0, 32'h0);
        add(1, 4'b0000, 32'h8, 32'h0, 6'b000000, 0, 0, 32'h0);
        add(1, 4'b0000, 32'h0, 32'h0, 6'b111111, 0, 0, 32'h0);
        add(1, 4'b0000, 32'h0, 32'h0, 6'b000000, 1, 1, EXC_VEC);
        add(1, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0);
        // reset during freeze abandons the flush
        add(1, 4'b0000, 32'h8, 32'h0, 6'b000000, 0, 0, 32'h0);
        add(0, 4'b0001, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0);
        add(1, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 1, 32'h0);
        add(1, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].exc, vecs[i].epc);
            #1;
            check6($sformatf("vec%0d_stall", i), stall, vecs[i].st);
            check6($sformatf("vec%0d_flush", i), {5'b0, flush}, {5'b0, vecs[i].fl});
            if (vecs[i].chk_pc) check32($sformatf("vec%0d_new_pc", i), new_pc, vecs[i].pc);
            @(posedge clk);
            @(negedge clk);
        end

        // perf counter: five cycles of an IF stall after the reset above
        repeat (5) begin
            drive(1'b1, 4'b0001, 32'h0, 32'h0);
            @(posedge clk);
            @(negedge clk);
        end
        drive(1'b1, 4'b0000, 32'h0, 32'h0);
        #1;
`ifdef PIPE_STALL_PERF_EN
        check32("perf_count5", stall_cycles, 32'd5);
`else
        check32("perf_tied0", stall_cycles, 32'h0);
`endif
        @(posedge clk);
        @(negedge clk);

        // randomized run against the schedule model
        m_cnt_known = 1'b0;
        m_target    = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            logic        r;
            logic [3:0]  q;
            logic [31:0] e, p;
            logic [5:0]  exp_st;
            int sel;
            r = (c == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            q = 4'b0000;
            for (int b = 0; b < 4; b++) q[b] = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 9);
            e = (sel == 0) ? 32'h8 : (sel == 1) ? ERET : (sel == 2) ? $urandom : 32'h0;
            p = $urandom;
            drive(r, q, e, p);
            #1;
            exp_st = model_stall(r, q, e);
            check6("rand_stall", stall, exp_st);
            if (m_cnt_known) begin
                check6("rand_flush", {5'b0, flush},
                       {5'b0, (sched_q.size() != 0 && sched_q[0] == 2)});
                if (sched_q.size() != 0 && sched_q[0] == 2) check32("rand_new_pc", new_pc, m_target);
`ifdef PIPE_STALL_PERF_EN
                check32("rand_perf", stall_cycles, m_cnt);
`else
                check32("rand_perf", stall_cycles, 32'h0);
`endif
            end
            @(posedge clk);
            model_edge(r, q, e, p, exp_st);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
